keypad_scanner: RTL and testbench

- Input-side counterpart of the 7-segment multiplex driver: time-multiplexed 4x4 matrix keypad scanner on the same lab board.
- Drives one column low per scan tick and reads the four row lines.
- Debounces a press and emits a single-cycle key event with a 4-bit code to downstream control logic.
- Shares the 1 kHz tick with the display path.

---
 rtl/keypad_scanner_pkg.sv | 41 ++++
 rtl/keypad_scanner_sync2.sv | 30 +++
 rtl/keypad_scanner.sv | 140 ++++++++++++++
 tb/tb_keypad_scanner.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner and its consumers:
// FSM encoding, keypad geometry and key-code to legend mapping.
package keypad_scanner_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int ROW_W    = 2;
  localparam int COL_W    = 2;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  // Physical legend printed on the lab keypad, indexed by row*4 + col.
  function automatic logic [7:0] key_legend(input logic [3:0] code);
    logic [7:0] ch;
    case (code)
      4'd0:    ch = "1";
      4'd1:    ch = "2";
      4'd2:    ch = "3";
      4'd3:    ch = "A";
      4'd4:    ch = "4";
      4'd5:    ch = "5";
      4'd6:    ch = "6";
      4'd7:    ch = "B";
      4'd8:    ch = "7";
      4'd9:    ch = "8";
      4'd10:   ch = "9";
      4'd11:   ch = "C";
      4'd12:   ch = "*";
      4'd13:   ch = "0";
      4'd14:   ch = "#";
      default: ch = "D";
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to RST_VAL so
// pulled-up lines read idle straight out of reset.
module sync2
  import keypad_scanner_pkg::*;
#(
  parameter int           W       = NUM_ROWS,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe on each scan
// tick, debounces press and release, and reports one event per accepted key.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1khz,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS);

  scan_state_e      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;

  logic [NUM_ROWS-1:0] row_s;
  logic [ROW_W-1:0]    first_low;
  logic                all_high;
  logic [CNT_W-1:0]    cnt_inc;

  sync2 #(.W(NUM_ROWS), .RST_VAL({NUM_ROWS{1'b1}})) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row_in),
    .q_o (row_s)
  );

  // Lowest-numbered low row wins when several keys share the column.
  always_comb begin
    first_low = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!row_s[i]) first_low = ROW_W'(i);
    end
  end

  assign all_high = &row_s;
  assign cnt_inc  = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    if (tick_1khz) begin
      case (state_q)
        ST_SCAN: begin
          if (all_high) begin
            col_d = col_q + 1'b1;
          end else begin
            row_idx_d = first_low;
            cnt_d     = CNT_W'(1);
            state_d   = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_s[row_idx_q]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              code_d  = {row_idx_q, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = ST_HELD;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (all_high) begin
            cnt_d   = CNT_W'(1);
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (all_high) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              cnt_d   = '0;
              held_d  = 1'b0;
              col_d   = col_q + 1'b1;
              state_d = ST_SCAN;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SCAN;
      col_q     <= '0;
      row_idx_q <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  // Decoding the column index guarantees exactly one low strobe bit.
  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    assign col_out[gi] = (col_q != COL_W'(gi));
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with DEBOUNCE_TICKS = 4 and a scan tick
// every 10 clocks; each step applies a row pattern, then one tick.
module tb_keypad_scanner;

  typedef struct {
    logic [3:0] rows;
    logic [3:0] col;
    logic       valid;
    logic       held;
    logic [3:0] code;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1khz = 1'b0;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int step_no  = 0;
  vec_t vq[$];

  keypad_scanner #(.DEBOUNCE_TICKS(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1khz (tick_1khz),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid === 1'b1) pulse_cnt++;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %b expected %b", name, step_no, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] c, input logic v,
                     input logic h, input logic [3:0] k);
    vec_t e;
    e.rows = r; e.col = c; e.valid = v; e.held = h; e.code = k;
    vq.push_back(e);
  endtask

  task automatic apply(input vec_t e);
    step_no++;
    row_in = e.rows;
    repeat (9) @(negedge clk);
    tick_1khz = 1'b1;
    @(negedge clk);
    tick_1khz = 1'b0;
    $display("step %0d rows=%b col=%b valid=%b held=%b code=%0d",
             step_no, e.rows, col_out, key_valid, key_held, key_code);
    check("col_out", col_out, e.col);
    check("key_valid", {3'b000, key_valid}, {3'b000, e.valid});
    check("key_held", {3'b000, key_held}, {3'b000, e.held});
    check("key_code", key_code, e.code);
  endtask

  initial begin
    // Scan from reset, clean press of key 9 (row 2 / col 1), release bounce
    add(4'hF, 4'b1101, 0, 0, 0); add(4'hF, 4'b1011, 0, 0, 0);
    add(4'hF, 4'b0111, 0, 0, 0); add(4'hF, 4'b1110, 0, 0, 0);
    add(4'hF, 4'b1101, 0, 0, 0);
    add(4'b1011, 4'b1101, 0, 0, 0); add(4'b1011, 4'b1101, 0, 0, 0);
    add(4'b1011, 4'b1101, 0, 0, 0); add(4'b1011, 4'b1101, 1, 1, 9);
    add(4'hF, 4'b1101, 0, 1, 9); add(4'hF, 4'b1101, 0, 1, 9);
    add(4'b1011, 4'b1101, 0, 1, 9);
    add(4'hF, 4'b1101, 0, 1, 9); add(4'hF, 4'b1101, 0, 1, 9);
    add(4'hF, 4'b1101, 0, 1, 9); add(4'hF, 4'b1011, 0, 0, 9);
    add(4'hF, 4'b0111, 0, 0, 9);
    // Press bounce on row 0 / col 3, twice, then a stable press -> code 3
    for (int rep = 0; rep < 2; rep++) begin
      add(4'b1110, 4'b0111, 0, 0, 9); add(4'b1110, 4'b0111, 0, 0, 9);
      add(4'hF, 4'b1110, 0, 0, 9);    add(4'hF, 4'b1101, 0, 0, 9);
      add(4'hF, 4'b1011, 0, 0, 9);    add(4'hF, 4'b0111, 0, 0, 9);
    end
    add(4'b1110, 4'b0111, 0, 0, 9); add(4'b1110, 4'b0111, 0, 0, 9);
    add(4'b1110, 4'b0111, 0, 0, 9); add(4'b1110, 4'b0111, 1, 1, 3);
    add(4'hF, 4'b0111, 0, 1, 3); add(4'hF, 4'b0111, 0, 1, 3);
    add(4'hF, 4'b0111, 0, 1, 3); add(4'hF, 4'b1110, 0, 0, 3);
    // Rows 1 and 3 together on col 0 -> row 1 wins, code 4; extra key ignored
    add(4'b0101, 4'b1110, 0, 0, 3); add(4'b0101, 4'b1110, 0, 0, 3);
    add(4'b0101, 4'b1110, 0, 0, 3); add(4'b0101, 4'b1110, 1, 1, 4);
    add(4'b0111, 4'b1110, 0, 1, 4);
    add(4'hF, 4'b1110, 0, 1, 4); add(4'hF, 4'b1110, 0, 1, 4);
    add(4'hF, 4'b1110, 0, 1, 4); add(4'hF, 4'b1101, 0, 0, 4);
    // Start a press on col 1, to be cut by reset at count 2
    add(4'b1011, 4'b1101, 0, 0, 4); add(4'b1011, 4'b1101, 0, 0, 4);

    repeat (3) @(negedge clk);
    check("rst col_out", col_out, 4'b1110);
    check("rst key_valid", {3'b000, key_valid}, 4'd0);
    check("rst key_held", {3'b000, key_held}, 4'd0);
    check("rst key_code", key_code, 4'd0);
    rst = 1'b0;

    foreach (vq[i]) apply(vq[i]);

    // Reset mid-debounce with a coincident tick; the key's column is no
    // longer driven afterwards, so the rows read idle.
    row_in = 4'hF;
    rst = 1'b1;
    tick_1khz = 1'b1;
    @(negedge clk);
    tick_1khz = 1'b0;
    rst = 1'b0;
    step_no++;
    $display("step %0d mid-debounce reset col=%b valid=%b held=%b code=%0d",
             step_no, col_out, key_valid, key_held, key_code);
    check("midrst col_out", col_out, 4'b1110);
    check("midrst key_valid", {3'b000, key_valid}, 4'd0);
    check("midrst key_held", {3'b000, key_held}, 4'd0);
    check("midrst key_code", key_code, 4'd0);

    vq.delete();
    add(4'hF, 4'b1101, 0, 0, 0); add(4'hF, 4'b1011, 0, 0, 0);
    add(4'hF, 4'b0111, 0, 0, 0); add(4'hF, 4'b1110, 0, 0, 0);
    add(4'hF, 4'b1101, 0, 0, 0); add(4'hF, 4'b1011, 0, 0, 0);
    foreach (vq[i]) apply(vq[i]);

    repeat (5) @(negedge clk);
    check("total key_valid pulses", 4'(pulse_cnt), 4'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
